// File: rtl/esl_to_binary_if.sv
// Stream/result bundle for esl_to_binary; raw window counts appear only when
// ESL_TO_BINARY_RAW_CNT_EN is defined.
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

interface esl_to_binary_if #(
  parameter int unsigned WIN_LOG2 = `BIN_LEN,
  parameter int unsigned OUT_LEN  = `BIN_LEN
);
  logic                enable;
  logic                clear;
  logic                in_x;
  logic                in_y;
  logic [OUT_LEN-1:0]  out_val;
  logic                out_valid;
  logic                out_sat;
  logic                div_zero;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
  logic [WIN_LOG2:0]   raw_cx;
  logic [WIN_LOG2:0]   raw_cy;

  modport master (output enable, clear, in_x, in_y,
                  input  out_val, out_valid, out_sat, div_zero, raw_cx, raw_cy);
  modport slave  (input  enable, clear, in_x, in_y,
                  output out_val, out_valid, out_sat, div_zero, raw_cx, raw_cy);
`else
  modport master (output enable, clear, in_x, in_y,
                  input  out_val, out_valid, out_sat, div_zero);
  modport slave  (input  enable, clear, in_x, in_y,
                  output out_val, out_valid, out_sat, div_zero);
`endif
endinterface

// File: rtl/esl_to_binary.sv
// Converts a pair of ESL bipolar streams (x/y) over a 2^WIN_LOG2 window into a
// signed fixed-point ratio. Optional macro: ESL_TO_BINARY_RAW_CNT_EN (raw counts).
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

module esl_to_binary #(
  parameter int unsigned WIN_LOG2 = `BIN_LEN,
  parameter int unsigned OUT_LEN  = `BIN_LEN
) (
  input  logic          clock,
  input  logic          reset,
  esl_to_binary_if.slave bus
);

  localparam int unsigned N  = 1 << WIN_LOG2;
  localparam int unsigned CW = WIN_LOG2 + 1;
  localparam int unsigned MW = WIN_LOG2 + 2;
  localparam int unsigned QW = OUT_LEN - 1;
  localparam int unsigned SW = $clog2(OUT_LEN) + 1;

  localparam logic [MW-1:0]      N_VAL     = MW'(N);
  localparam logic [OUT_LEN-1:0] MAX_POS   = {1'b0, {QW{1'b1}}};
  localparam logic [OUT_LEN-1:0] MIN_NEG   = {1'b1, {QW{1'b0}}};
  localparam logic [SW-1:0]      LAST_STEP = SW'(OUT_LEN - 2);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_e;

  state_e                state_q, state_d;
  logic [WIN_LOG2-1:0]   win_q, win_d;
  logic [CW-1:0]         cx_q, cx_d, cy_q, cy_d;
  logic signed [MW-1:0]  num_q, num_d, den_q, den_d;
  logic [MW-1:0]         rem_q, rem_d, dvs_q, dvs_d;
  logic [QW-1:0]         quo_q, quo_d;
  logic [SW-1:0]         step_q, step_d;
  logic                  neg_q, neg_d;
  logic                  ovr_q, ovr_d;
  logic                  sat_q, sat_d;
  logic                  dz_q, dz_d;
  logic [OUT_LEN-1:0]    ovr_val_q, ovr_val_d;
  logic [OUT_LEN-1:0]    out_val_q, out_val_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sat_q, out_sat_d;
  logic                  div_zero_q, div_zero_d;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
  logic [CW-1:0]         cap_cx_q, cap_cx_d, cap_cy_q, cap_cy_d;
  logic [CW-1:0]         raw_cx_q, raw_cx_d, raw_cy_q, raw_cy_d;
`endif

  logic [CW-1:0]         cx_sum, cy_sum;
  logic                  win_end;
  logic [MW-1:0]         num_mag, den_mag, rem_sh;
  logic                  rem_ge;
  logic [OUT_LEN-1:0]    quo_ext;

  always_comb begin
    cx_sum  = cx_q + CW'(bus.enable & bus.in_x);
    cy_sum  = cy_q + CW'(bus.enable & bus.in_y);
    win_end = bus.enable && (win_q == '1) && !bus.clear;
    num_mag = num_q[MW-1] ? MW'(-num_q) : MW'(num_q);
    den_mag = den_q[MW-1] ? MW'(-den_q) : MW'(den_q);
    rem_sh  = MW'({rem_q, 1'b0});
    rem_ge  = (rem_sh >= dvs_q);
    quo_ext = {1'b0, quo_q};
  end

  // Window accumulation: the closing sample is folded into num/den directly so
  // the next window's first sample lands in freshly zeroed counters.
  always_comb begin
    win_d = win_q + WIN_LOG2'(bus.enable);
    cx_d  = cx_sum;
    cy_d  = cy_sum;
    num_d = num_q;
    den_d = den_q;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
    cap_cx_d = cap_cx_q;
    cap_cy_d = cap_cy_q;
`endif
    if (bus.clear) begin
      win_d = '0;
      cx_d  = '0;
      cy_d  = '0;
    end else if (win_end) begin
      cx_d  = '0;
      cy_d  = '0;
      num_d = $signed({cx_sum, 1'b0} - N_VAL);
      den_d = $signed({cy_sum, 1'b0} - N_VAL);
`ifdef ESL_TO_BINARY_RAW_CNT_EN
      cap_cx_d = cx_sum;
      cap_cy_d = cy_sum;
`endif
    end
  end

  // Saturating / zero-denominator outcomes still traverse DIV so every result
  // emerges with the same fixed latency; the override replaces the quotient.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    step_d      = step_q;
    neg_d       = neg_q;
    ovr_d       = ovr_q;
    sat_d       = sat_q;
    dz_d        = dz_q;
    ovr_val_d   = ovr_val_q;
    out_val_d   = out_val_q;
    out_sat_d   = out_sat_q;
    div_zero_d  = div_zero_q;
    out_valid_d = 1'b0;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
    raw_cx_d = raw_cx_q;
    raw_cy_d = raw_cy_q;
`endif
    unique case (state_q)
      IDLE: ;
      CHECK: begin
        rem_d     = num_mag;
        dvs_d     = den_mag;
        quo_d     = '0;
        step_d    = '0;
        neg_d     = num_q[MW-1] ^ den_q[MW-1];
        ovr_d     = 1'b0;
        sat_d     = 1'b0;
        dz_d      = 1'b0;
        ovr_val_d = '0;
        if (den_q == '0) begin
          ovr_d = 1'b1;
          dz_d  = 1'b1;
          if (num_q != '0) begin
            sat_d     = 1'b1;
            ovr_val_d = num_q[MW-1] ? MIN_NEG : MAX_POS;
          end
        end else if (num_mag >= den_mag) begin
          ovr_d     = 1'b1;
          sat_d     = 1'b1;
          ovr_val_d = (num_q[MW-1] == den_q[MW-1]) ? MAX_POS : MIN_NEG;
        end
        state_d = DIV;
      end
      DIV: begin
        rem_d  = rem_ge ? (rem_sh - dvs_q) : rem_sh;
        quo_d  = QW'({quo_q, rem_ge});
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (ovr_q)      out_val_d = ovr_val_q;
        else if (neg_q) out_val_d = ~quo_ext + OUT_LEN'(1);
        else            out_val_d = quo_ext;
        out_sat_d   = sat_q;
        div_zero_d  = dz_q;
        out_valid_d = 1'b1;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
        raw_cx_d = cap_cx_q;
        raw_cy_d = cap_cy_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d     = IDLE;
      out_val_d   = out_val_q;
      out_sat_d   = out_sat_q;
      div_zero_d  = div_zero_q;
      out_valid_d = 1'b0;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
      raw_cx_d = raw_cx_q;
      raw_cy_d = raw_cy_q;
`endif
    end else if (win_end) begin
      state_d = CHECK;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      neg_q       <= 1'b0;
      ovr_q       <= 1'b0;
      sat_q       <= 1'b0;
      dz_q        <= 1'b0;
      ovr_val_q   <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      div_zero_q  <= 1'b0;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
      cap_cx_q    <= '0;
      cap_cy_q    <= '0;
      raw_cx_q    <= '0;
      raw_cy_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      num_q       <= num_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      step_q      <= step_d;
      neg_q       <= neg_d;
      ovr_q       <= ovr_d;
      sat_q       <= sat_d;
      dz_q        <= dz_d;
      ovr_val_q   <= ovr_val_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      div_zero_q  <= div_zero_d;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
      cap_cx_q    <= cap_cx_d;
      cap_cy_q    <= cap_cy_d;
      raw_cx_q    <= raw_cx_d;
      raw_cy_q    <= raw_cy_d;
`endif
    end
  end

  assign bus.out_val   = out_val_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.div_zero  = div_zero_q;
`ifdef ESL_TO_BINARY_RAW_CNT_EN
  assign bus.raw_cx    = raw_cx_q;
  assign bus.raw_cy    = raw_cy_q;
`endif

endmodule

// File: tb/tb_esl_to_binary.sv
// Directed bench for esl_to_binary with WIN_LOG2=8, OUT_LEN=8 (N=256).
module tb_esl_to_binary;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  esl_to_binary_if #(.WIN_LOG2(8), .OUT_LEN(8)) bus ();

  esl_to_binary #(.WIN_LOG2(8), .OUT_LEN(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (bus.out_valid === 1'b1) valid_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 256 enabled samples; the first nx/ny samples of x/y are ones.
  task automatic run_window(input int nx, input int ny);
    for (int i = 0; i < 256; i++) begin
      bus.enable = 1'b1;
      bus.in_x   = (i < nx);
      bus.in_y   = (i < ny);
      tick();
    end
    bus.enable = 1'b0;
    bus.in_x   = 1'b0;
    bus.in_y   = 1'b0;
  endtask

  // Called #1 after the last-sample edge (lat edges before the pulse).
  task automatic expect_result(input string tag, input int lat, input logic [7:0] ev,
                               input logic es, input logic ed);
    int early;
    early = 0;
    for (int k = 1; k < lat; k++) begin
      tick();
      if (bus.out_valid === 1'b1) early++;
    end
    tick();
    chk({tag, " early"}, early, 0);
    chk({tag, " valid"}, bus.out_valid, 1);
    chk({tag, " val"},   bus.out_val, ev);
    chk({tag, " sat"},   bus.out_sat, es);
    chk({tag, " dz"},    bus.div_zero, ed);
    tick();
    chk({tag, " pulse"}, bus.out_valid, 0);
    tick();
    chk({tag, " hold"},  bus.out_val, ev);
  endtask

  initial begin
    int snap;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    bus.in_x   = 1'b0;
    bus.in_y   = 1'b0;
    #1;
    chk("rst val",   bus.out_val, 0);
    chk("rst valid", bus.out_valid, 0);
    chk("rst sat",   bus.out_sat, 0);
    chk("rst dz",    bus.div_zero, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    run_window(256, 256); expect_result("all_ones",   9, 8'h7F, 1'b1, 1'b0);
    run_window(192, 256); expect_result("half",       9, 8'h40, 1'b0, 1'b0);
    run_window(64, 256);  expect_result("neg_half",   9, 8'hC0, 1'b0, 1'b0);
    run_window(160, 224); expect_result("third",      9, 8'h2A, 1'b0, 1'b0);
    run_window(200, 128); expect_result("dz_pos",     9, 8'h7F, 1'b1, 1'b1);
    run_window(128, 128); expect_result("dz_zero",    9, 8'h00, 1'b0, 1'b1);
    run_window(0, 128);   expect_result("dz_neg",     9, 8'h80, 1'b1, 1'b1);
    run_window(0, 256);   expect_result("sat_neg",    9, 8'h80, 1'b1, 1'b0);
    run_window(96, 32);   expect_result("neg_neg",    9, 8'h2A, 1'b0, 1'b0);
    run_window(160, 32);  expect_result("pos_negden", 9, 8'hD6, 1'b0, 1'b0);
    run_window(128, 0);   expect_result("zero_num",   9, 8'h00, 1'b0, 1'b0);

    // enable every other cycle: 256 enabled samples, last one at cycle 510
    snap = valid_cnt;
    for (int i = 0; i < 512; i++) begin
      bus.enable = (i % 2 == 0);
      bus.in_x   = 1'b1;
      bus.in_y   = 1'b1;
      tick();
    end
    bus.enable = 1'b0;
    chk("toggle none_early", valid_cnt - snap, 0);
    expect_result("toggle", 8, 8'h7F, 1'b1, 1'b0);
    repeat (3) tick();
    chk("toggle single", valid_cnt - snap, 1);

    // clear on the closing sample suppresses the result
    snap = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      bus.enable = 1'b1;
      bus.in_x   = 1'b1;
      bus.in_y   = 1'b1;
      bus.clear  = (i == 255);
      tick();
    end
    bus.clear  = 1'b0;
    bus.enable = 1'b0;
    repeat (14) tick();
    chk("clear_at_end none", valid_cnt - snap, 0);
    run_window(64, 256); expect_result("after_clear_end", 9, 8'hC0, 1'b0, 1'b0);

    // clear at cycle 100 restarts the window
    for (int i = 0; i <= 100; i++) begin
      bus.enable = 1'b1;
      bus.in_x   = 1'b1;
      bus.in_y   = 1'b1;
      bus.clear  = (i == 100);
      tick();
    end
    bus.clear = 1'b0;
    run_window(192, 256); expect_result("clear_mid", 9, 8'h40, 1'b0, 1'b0);

    // reset after 50 samples of a window discards it
    for (int i = 0; i < 50; i++) begin
      bus.enable = 1'b1;
      bus.in_x   = 1'b1;
      bus.in_y   = 1'b1;
      tick();
    end
    bus.enable = 1'b0;
    reset = 1'b0;
    #1;
    chk("async rst val", bus.out_val, 0);
    chk("async rst sat", bus.out_sat, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    snap = valid_cnt;
    run_window(256, 256);
    chk("post_reset none_early", valid_cnt - snap, 0);
    expect_result("post_reset", 9, 8'h7F, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esl_to_binary.md
ESL_TO_BINARY -- requirements
Module: esl_to_binary

Interface
REQ-001 Parameter WIN_LOG2, default `BIN_LEN: window length N = 2^WIN_LOG2 clock cycles; legal range 4..16.
REQ-002 Parameter OUT_LEN, default `BIN_LEN: result width; legal only when OUT_LEN+2 <= N.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  sample-qualify; stream bits counted only when high.
REQ-006 clear  input  1  synchronous restart of window and divider.
REQ-007 in_x  input  1  ESL numerator bipolar stream bit.
REQ-008 in_y  input  1  ESL denominator bipolar stream bit.
REQ-009 out_val  output  OUT_LEN  signed two's-complement result, OUT_LEN-1 fraction bits.
REQ-010 out_valid  output  1  one-cycle pulse marking a new out_val.
REQ-011 out_sat  output  1  result saturated; valid with out_valid.
REQ-012 div_zero  output  1  denominator was zero; valid with out_valid.

Function
REQ-013 Counters cx, cy (WIN_LOG2+1 bits) SHALL increment on in_x/in_y high when enable high; window counter SHALL advance only when enable high.
REQ-014 On the last sample of a window, num=2*cx-N and den=2*cy-N (signed, WIN_LOG2+2 bits) SHALL be captured next cycle; counters SHALL zero and the next window SHALL start with no lost sample.
REQ-015 Divider FSM states IDLE -> CHECK (1 cycle) -> DIV (OUT_LEN-1 cycles) -> DONE (1 cycle) -> IDLE.
REQ-016 CHECK: den==0 -> DONE with div_zero=1; out_val=0 if num==0, else 0x7F..F for num>0, 0x80..0 for num<0; out_sat=1 if num!=0.
REQ-017 CHECK: |num|>=|den| -> DONE with out_sat=1; out_val=max positive if signs equal, min negative otherwise.
REQ-018 DIV: restoring division on magnitudes, one quotient bit per cycle, MSB first; quotient truncated toward zero; sign applied as sign(num) XOR sign(den).
REQ-019 DONE: out_val, out_sat, div_zero SHALL be registered and out_valid pulsed high exactly one cycle, OUT_LEN+1 cycles after the window's last sample.
REQ-020 out_val, out_sat, div_zero SHALL hold between pulses.
REQ-021 enable low SHALL freeze counting only; an in-flight division SHALL continue.
REQ-022 clear SHALL zero cx, cy, window counter and return FSM to IDLE with no out_valid; clear coincident with window end SHALL win (no result).
REQ-023 A window end while the FSM is not IDLE cannot occur under REQ-002.

Reset
REQ-024 reset low SHALL asynchronously zero counters, window counter, num, den, out_val, out_valid, out_sat, div_zero and force FSM to IDLE.
REQ-025 reset mid-window or mid-division SHALL discard that window; first out_valid after release follows a full N enabled samples.

Configuration
REQ-026 Macro ESL_TO_BINARY_RAW_CNT_EN defined: extra outputs raw_cx, raw_cy (WIN_LOG2+1 bits each) SHALL present the captured window counts, updated with out_valid, reset to 0.
REQ-027 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Verification (WIN_LOG2=8, OUT_LEN=8, N=256, enable=1)
REQ-028 in_x=1, in_y=1 for 256 cycles -> out_val=0x7F, out_sat=1, div_zero=0, out_valid 9 cycles after last sample.
REQ-029 in_x 192 ones, in_y 256 ones -> out_val=0x40, out_sat=0; in_x 64 ones -> out_val=0xC0.
REQ-030 in_x 160 ones, in_y 224 ones -> num=64, den=192 -> out_val=0x2A (truncated 1/3).
REQ-031 in_y 128 ones, in_x 200 ones -> div_zero=1, out_sat=1, out_val=0x7F; in_x 128 ones -> out_val=0x00, out_sat=0.
REQ-032 clear at cycle 100 of a window, then reset low at cycle 50 of next -> no out_valid until 256 enabled samples after reset release.
REQ-033 enable toggled every other cycle over 512 cycles with constant streams -> identical result to REQ-028, one out_valid.
